// File: rtl/parking_pkg.sv
// Shared types and constants for the parking exit path.
//   state_e            : exit FSM states (IDLE, OPEN)
//   SLOT_W             : width of a slot index
//   DEF_SLOTS          : default number of parking slots
//   DEF_TIMEOUT_CYCLES : default gate-open timeout in cycles
package parking_pkg;

  localparam int unsigned SLOT_W             = 3;
  localparam int unsigned DEF_SLOTS          = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_e;

endpackage : parking_pkg

// File: rtl/exit_timer.sv
// Counts cycles while enabled and flags when the count has reached
// TIMEOUT_CYCLES-1. Only instantiated when EXIT_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : force the count to zero (wins over enable)
//   enable     : advance the count by one
//   expired    : registered, high while count == TIMEOUT_CYCLES-1
module exit_timer #(
  parameter int unsigned TIMEOUT_CYCLES = parking_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  // Next count; expiry is decoded from the next count so the flag is registered.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = (count_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule : exit_timer

// File: rtl/exit_controller.sv
// Exit gate controller and owner of the free-slot bitmap.
// A car leaving a valid (occupied) slot opens the gate; when the exit
// sensor reports the car has passed, the slot is freed and exit_ack pulses.
// Requests on already-free slots pulse exit_err. The entry side may mark
// a slot occupied at any time; occupy wins over a same-slot release.
// Optional: define EXIT_TIMEOUT_EN to abort an open gate (exit_err) after
// TIMEOUT_CYCLES cycles without car_passed.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   exit_req/exit_slot: exit request and slot being vacated (IDLE only)
//   car_passed        : exit sensor, car cleared the gate
//   occupy_valid/slot : entry side parked a car in occupy_slot
//   parking_capacity  : registered free-slot bitmap (1 = free)
//   gate_open         : registered gate drive
//   exit_ack/exit_err : one-cycle completion / error pulses
//   busy              : high while in OPEN
module exit_controller
  import parking_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SLOTS          = DEF_SLOTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  input  logic              car_passed,
  input  logic              occupy_valid,
  input  logic [SLOT_W-1:0] occupy_slot,
  output logic [SLOTS-1:0]  parking_capacity,
  output logic              gate_open,
  output logic              exit_ack,
  output logic              exit_err,
  output logic              busy
);

  // Elaboration-time sanity check on the configuration.
  if (TIMEOUT_CYCLES == 0 || SLOTS == 0 || SLOTS > (1 << SLOT_W)) begin : g_bad_cfg
    $error("exit_controller: unsupported TIMEOUT_CYCLES/SLOTS");
  end

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOTS-1:0]  cap_q, cap_d;
  logic              gate_q, gate_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

`ifdef EXIT_TIMEOUT_EN
  logic timer_expired;

  // Timer is held at zero outside OPEN so it starts from 0 on gate opening.
  exit_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_exit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != OPEN),
    .enable  (state_q == OPEN),
    .expired (timer_expired)
  );
`endif

  // Next-state, bitmap and output pulses.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cap_d   = cap_q;
    gate_d  = gate_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Validity is checked against the pre-edge bitmap.
        if (exit_req) begin
          if (!cap_q[exit_slot]) begin
            slot_d  = exit_slot;
            gate_d  = 1'b1;
            state_d = OPEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OPEN: begin
        // car_passed beats a simultaneous timeout.
        if (car_passed) begin
          cap_d[slot_q] = 1'b1;
          ack_d         = 1'b1;
          gate_d        = 1'b0;
          state_d       = IDLE;
        end
`ifdef EXIT_TIMEOUT_EN
        else if (timer_expired) begin
          err_d   = 1'b1;
          gate_d  = 1'b0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Applied last so an occupy overrides a same-slot release.
    if (occupy_valid) begin
      cap_d[occupy_slot] = 1'b0;
    end

    busy_d = (state_d == OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cap_q   <= '1;
      gate_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cap_q   <= cap_d;
      gate_q  <= gate_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign parking_capacity = cap_q;
  assign gate_open        = gate_q;
  assign exit_ack         = ack_q;
  assign exit_err         = err_q;
  assign busy             = busy_q;

endmodule : exit_controller

// File: tb/tb_exit_controller.sv
// Scoreboard bench for exit_controller: stimulus pushes the expected
// ack/err event (with the bitmap expected alongside it); a monitor pops
// and compares whenever exit_ack or exit_err is seen.
module tb_exit_controller;
  import parking_pkg::*;

  localparam int unsigned TO    = 10;
  localparam int unsigned NSLOT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic              car_passed;
  logic              occupy_valid;
  logic [SLOT_W-1:0] occupy_slot;
  logic [NSLOT-1:0]  parking_capacity;
  logic              gate_open, exit_ack, exit_err, busy;

  typedef struct {
    bit              is_err;
    logic [NSLOT-1:0] cap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  exit_controller #(
    .TIMEOUT_CYCLES (TO),
    .SLOTS          (NSLOT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exit_req         (exit_req),
    .exit_slot        (exit_slot),
    .car_passed       (car_passed),
    .occupy_valid     (occupy_valid),
    .occupy_slot      (occupy_slot),
    .parking_capacity (parking_capacity),
    .gate_open        (gate_open),
    .exit_ack         (exit_ack),
    .exit_err         (exit_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [NSLOT-1:0] cap);
    exp_t e;
    e.is_err = is_err;
    e.cap    = cap;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (exit_ack === 1'b1 || exit_err === 1'b1)) begin
      chk("ack_err_exclusive", 32'(exit_ack & exit_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, exit_err, exit_ack}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_kind_err", 32'(exit_err), 32'(e.is_err));
        chk("event_kind_ack", 32'(exit_ack), 32'(!e.is_err));
        chk("event_capacity", 32'(parking_capacity), 32'(e.cap));
      end
    end
  end

  task automatic occupy(input int s);
    occupy_valid = 1'b1;
    occupy_slot  = SLOT_W'(s);
    cyc();
    occupy_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    exit_req     = 1'b0;
    exit_slot    = '0;
    car_passed   = 1'b0;
    occupy_valid = 1'b0;
    occupy_slot  = '0;
    repeat (2) cyc();

    // Reset state
    chk("rst_cap",  32'(parking_capacity), 32'hFF);
    chk("rst_gate", 32'(gate_open), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'(exit_ack | exit_err), 32'd0);
    rst_n = 1'b1;

    // Normal exit of slot 3, car passes 5 cycles after the request
    occupy(3);
    chk("occ3_cap", 32'(parking_capacity), 32'hF7);
    exit_req = 1'b1; exit_slot = 3'd3;
    cyc();
    exit_req = 1'b0;
    chk("open3_gate", 32'(gate_open), 32'd1);
    chk("open3_busy", 32'(busy), 32'd1);
    repeat (4) cyc();
    chk("open3_still", 32'(gate_open), 32'd1);
    car_passed = 1'b1;
    push(1'b0, 8'hFF);
    cyc();
    car_passed = 1'b0;
    chk("done3_cap",  32'(parking_capacity), 32'hFF);
    chk("done3_gate", 32'(gate_open), 32'd0);
    chk("done3_busy", 32'(busy), 32'd0);
    chk("done3_ack",  32'(exit_ack), 32'd1);
    cyc();
    chk("done3_ack_once", 32'(exit_ack), 32'd0);

    // Invalid request: slot 5 already free
    exit_req = 1'b1; exit_slot = 3'd5;
    push(1'b1, 8'hFF);
    cyc();
    exit_req = 1'b0;
    chk("inv5_err",  32'(exit_err), 32'd1);
    chk("inv5_busy", 32'(busy), 32'd0);
    chk("inv5_gate", 32'(gate_open), 32'd0);
    chk("inv5_cap",  32'(parking_capacity), 32'hFF);
    cyc();
    chk("inv5_err_once", 32'(exit_err), 32'd0);

    // car_passed in IDLE is ignored
    car_passed = 1'b1;
    cyc();
    car_passed = 1'b0;
    chk("idle_cp_busy", 32'(busy), 32'd0);
    chk("idle_cp_cap",  32'(parking_capacity), 32'hFF);

    // Slot 2: exit_req in OPEN ignored; occupy same slot as car_passed wins
    occupy(2);
    exit_req = 1'b1; exit_slot = 3'd2;
    cyc();
    exit_slot = 3'd4;
    cyc();
    exit_req = 1'b0;
    chk("open2_busy", 32'(busy), 32'd1);
    chk("open2_err",  32'(exit_err), 32'd0);
    car_passed = 1'b1; occupy_valid = 1'b1; occupy_slot = 3'd2;
    push(1'b0, 8'hFB);
    cyc();
    car_passed = 1'b0; occupy_valid = 1'b0;
    chk("same_slot_cap",  32'(parking_capacity), 32'hFB);
    chk("same_slot_gate", 32'(gate_open), 32'd0);
    chk("same_slot_ack",  32'(exit_ack), 32'd1);

    // Release slot 2 while occupying slot 6 on the same edge
    exit_req = 1'b1; exit_slot = 3'd2;
    cyc();
    exit_req = 1'b0;
    car_passed = 1'b1; occupy_valid = 1'b1; occupy_slot = 3'd6;
    push(1'b0, 8'hBF);
    cyc();
    car_passed = 1'b0; occupy_valid = 1'b0;
    chk("diff_slot_cap", 32'(parking_capacity), 32'hBF);

    // exit_req and occupy of free slot 0 on one edge: checked pre-edge -> error
    exit_req = 1'b1; exit_slot = 3'd0; occupy_valid = 1'b1; occupy_slot = 3'd0;
    push(1'b1, 8'hBE);
    cyc();
    exit_req = 1'b0; occupy_valid = 1'b0;
    chk("preedge_err",  32'(exit_err), 32'd1);
    chk("preedge_cap",  32'(parking_capacity), 32'hBE);
    chk("preedge_busy", 32'(busy), 32'd0);

    // Slot 6 open, no car_passed
    exit_req = 1'b1; exit_slot = 3'd6;
    cyc();
    exit_req = 1'b0;
    chk("open6_gate", 32'(gate_open), 32'd1);
`ifdef EXIT_TIMEOUT_EN
    for (int i = 1; i < int'(TO); i++) begin
      cyc();
      chk("to_wait_gate", 32'(gate_open), 32'd1);
      chk("to_wait_err",  32'(exit_err), 32'd0);
    end
    push(1'b1, 8'hBE);
    cyc();
    chk("to_err",  32'(exit_err), 32'd1);
    chk("to_gate", 32'(gate_open), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cap",  32'(parking_capacity), 32'hBE);
`else
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("wait_gate", 32'(gate_open), 32'd1);
    end
    car_passed = 1'b1;
    push(1'b0, 8'hFE);
    cyc();
    car_passed = 1'b0;
    chk("late_cap",  32'(parking_capacity), 32'hFE);
    chk("late_gate", 32'(gate_open), 32'd0);
`endif

    // Reset asserted while OPEN on slot 1
    occupy(1);
    exit_req = 1'b1; exit_slot = 3'd1;
    cyc();
    exit_req = 1'b0;
    chk("open1_gate", 32'(gate_open), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gate",   32'(gate_open), 32'd0);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_cap",    32'(parking_capacity), 32'hFF);
    chk("midrst_pulses", 32'(exit_ack | exit_err), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // First edge after reset is an ordinary IDLE cycle
    exit_req = 1'b1; exit_slot = 3'd4;
    push(1'b1, 8'hFF);
    cyc();
    exit_req = 1'b0;
    chk("post_rst_err", 32'(exit_err), 32'd1);
    repeat (3) cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_exit_controller
